wavegen: RTL and testbench
==========================

Name: wavegen

Overview:
- Parametrised successor of the single-width 8-bit waveform counter.
- Generates saw, reverse saw, triangle, 50% meander and programmable-duty PWM from one phase accumulator with programmable step.
- Also provides a registered, mode-selected output and a period-wrap strobe.
- Feeds DAC/PWM output stages; all outputs are WIDTH-bit unsigned codes.

Parameters:
- WIDTH, 8, sample/phase width in bits (≥3).
- STEP_W, 8, width of the phase-step input (≤ WIDTH).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- en, input, 1, advance enable; low freezes all state.
- step, input, STEP_W, phase increment per enabled cycle, zero-extended.
- duty, input, WIDTH, PWM high threshold; sampled only at wrap.
- mode, input, 2, wave_out select; sampled only at wrap.
- saw, output, WIDTH, rising ramp (= acc).
- revsaw, output, WIDTH, falling ramp (= ~acc).
- triangl, output, WIDTH, up/down triangle.
- meander, output, WIDTH, all-ones while acc MSB=0, else all-zeros.
- pwm, output, WIDTH, all-ones while acc < duty_q, else all-zeros.
- wave_out, output, WIDTH, registered copy of the waveform chosen by mode_q.
- wrap, output, 1, one-cycle pulse on accumulator overflow.

Behaviour:
- Reset (async, active-high, clk domain):
  - acc=0, tri=0, dir=UP, duty_q=2^(WIDTH-2) (25%), mode_q=SAW, wave_out=0, wrap=0.
  - Resulting outputs: saw=0, revsaw=all-ones, meander=all-ones, pwm=all-ones.
- Accumulator:
  - When en=1: acc <= (acc+step) mod 2^WIDTH.
  - wrap <= carry-out of that add; wrap=0 whenever en=0.
  - step=0 with en=1: acc holds, no wrap.
- Wrap-boundary capture: on any cycle with a carry, duty_q<=duty and mode_q<=mode. Mid-period changes are therefore glitch-free and take effect from the first post-wrap sample.
- Triangle FSM, states UP/DOWN, advances only when en=1:
  - UP: if tri+step ≥ 2^WIDTH-1 then tri<=max and dir<=DOWN; else tri<=tri+step.
  - DOWN: if tri ≤ step then tri<=0 and dir<=UP; else tri<=tri-step.
  - Peak and trough values are each held for exactly one sample per direction change.
  - The FSM is independent of acc; the periods differ.
- saw, revsaw, meander, pwm and triangl are combinational from registers (0-cycle latency after state update).
- wave_out is registered, 1-cycle latency from the selected source. mode_q: 0=saw, 1=revsaw, 2=triangl, 3=pwm.
- Boundaries:
  - duty=0: pwm always zero.
  - duty=all-ones: pwm zero only at acc=max.
  - Reset asserted mid-period overrides everything immediately, including a wrap in flight.
  - en deasserted on the wrap cycle: no wrap and no capture.

Optional Feature:
- Macro: WAVEGEN_SYNC_EN.
- Defined: adds input port sync (1 bit). On sync=1 the next clock edge sets acc<=0, tri<=0, dir<=UP and duty_q/mode_q<=inputs. sync has priority over en, and no wrap pulse is emitted.
- Undefined: port absent, no resync path.

Decomposition:
- Package wavegen_pkg holds:
  - mode constants MODE_SAW=2'd0, MODE_REVSAW=2'd1, MODE_TRI=2'd2, MODE_PWM=2'd3;
  - direction constants DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module wavegen_tri contains the triangle FSM (params WIDTH, STEP_W; ports clk, reset, en, step, tri, dir).
- Top-level contains accumulator, captures and output mux.

Test Plan (WIDTH=8, STEP_W=8, 20 ns clock, reset for the first 100 ns):
- Reset then en=1, step=1: saw 0,1,…,255,0. wrap high only on the cycle acc goes 255→0, i.e. every 256 cycles. revsaw = 255-saw.
- step=1: triangl 0→255 in 255 cycles, then 254→0, period 510 cycles. step=100: sequence 0,100,200,255,155,55,0,100.
- duty=64 written mid-period: pwm stays at the 25% reset threshold until the next wrap, then 64 cycles of 255 and 192 cycles of 0. meander is 128 high / 128 low.
- step=3 from acc=254: next acc=1 with wrap=1. mode=2 written at that cycle: wave_out shows triangl starting one cycle after the wrap.
- en=0 for 50 cycles mid-ramp: all outputs frozen, wrap=0. Resume continues from the held values.
- reset pulsed for 30 ns mid-period: outputs are at reset values before the next clock edge. With WAVEGEN_SYNC_EN, a sync pulse at acc=77 gives acc=0, triangl=0 and no wrap.

Source files
------------

// File: rtl/wavegen_pkg.sv
// -----------------------------------------------------------------------------
// wavegen_pkg
// Shared constants for the waveform generator.
//   mode_e : wave_out source select (captured at the accumulator wrap)
//   dir_e  : triangle generator direction
// Optional build macro used by the files importing this package: WAVEGEN_SYNC_EN
// -----------------------------------------------------------------------------
package wavegen_pkg;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_REVSAW = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_PWM    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/wavegen_if.sv
// -----------------------------------------------------------------------------
// wavegen_if
// Control and sample bus of the waveform generator.
//   master : drives en/step/duty/mode (and sync when WAVEGEN_SYNC_EN is defined),
//            observes the waveform outputs
//   slave  : the generator itself
// Signals:
//   en       advance enable            step     phase increment (zero-extended)
//   duty     PWM threshold (at wrap)   mode     wave_out select (at wrap)
//   saw/revsaw/triangl/meander/pwm     WIDTH-bit unsigned waveform codes
//   wave_out registered selected wave  wrap     one-cycle accumulator overflow pulse
//   sync     (WAVEGEN_SYNC_EN only) phase restart request
// -----------------------------------------------------------------------------
interface wavegen_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
);
  logic              en;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  duty;
  logic [1:0]        mode;
`ifdef WAVEGEN_SYNC_EN
  logic              sync;
`endif
  logic [WIDTH-1:0]  saw;
  logic [WIDTH-1:0]  revsaw;
  logic [WIDTH-1:0]  triangl;
  logic [WIDTH-1:0]  meander;
  logic [WIDTH-1:0]  pwm;
  logic [WIDTH-1:0]  wave_out;
  logic              wrap;

  modport master (
`ifdef WAVEGEN_SYNC_EN
    output sync,
`endif
    output en, step, duty, mode,
    input  saw, revsaw, triangl, meander, pwm, wave_out, wrap
  );

  modport slave (
`ifdef WAVEGEN_SYNC_EN
    input  sync,
`endif
    input  en, step, duty, mode,
    output saw, revsaw, triangl, meander, pwm, wave_out, wrap
  );
endinterface

// File: rtl/wavegen_tri.sv
// -----------------------------------------------------------------------------
// wavegen_tri
// Up/down triangle generator. Runs independently of the phase accumulator:
// it climbs by step until it clips at full scale, then falls by step until it
// clips at zero. Each clip value is held for exactly one sample.
// Ports:
//   clk, reset (async, active-high), en (advance), step (increment),
//   sync (WAVEGEN_SYNC_EN only: restart at zero going up),
//   tri_val (current triangle sample), dir (current direction)
// -----------------------------------------------------------------------------
module wavegen_tri
  import wavegen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
`ifdef WAVEGEN_SYNC_EN
  input  logic              sync,
`endif
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  tri_val,
  output dir_e              dir
);

  localparam logic [WIDTH-1:0] MAX_CODE = '1;

  logic [WIDTH-1:0] r_tri;
  dir_e             r_dir;
  logic [WIDTH:0]   w_step_x;
  logic [WIDTH:0]   w_up_sum;

  // One guard bit so the rising compare cannot wrap around.
  assign w_step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign w_up_sum = {1'b0, r_tri} + w_step_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tri <= '0;
      r_dir <= DIR_UP;
    end else begin
`ifdef WAVEGEN_SYNC_EN
      if (sync) begin
        r_tri <= '0;
        r_dir <= DIR_UP;
      end else
`endif
      if (en) begin
        case (r_dir)
          DIR_UP: begin
            if (w_up_sum >= {1'b0, MAX_CODE}) begin
              r_tri <= MAX_CODE;
              r_dir <= DIR_DOWN;
            end else begin
              r_tri <= w_up_sum[WIDTH-1:0];
            end
          end
          DIR_DOWN: begin
            if (r_tri <= w_step_x[WIDTH-1:0]) begin
              r_tri <= '0;
              r_dir <= DIR_UP;
            end else begin
              r_tri <= r_tri - w_step_x[WIDTH-1:0];
            end
          end
        endcase
      end
    end
  end

  assign tri_val = r_tri;
  assign dir     = r_dir;

endmodule

// File: rtl/wavegen.sv
// -----------------------------------------------------------------------------
// wavegen
// Multi-waveform generator driven from one phase accumulator with programmable
// step: saw, reverse saw, 50% meander and programmable-duty PWM, plus an
// independent triangle (wavegen_tri), a registered mode-selected output and a
// one-cycle wrap strobe. duty and mode are only taken at the accumulator wrap
// so a mid-period change never produces a partial period.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : wavegen_if.slave (en, step, duty, mode, [sync] in;
//           saw, revsaw, triangl, meander, pwm, wave_out, wrap out)
// Build option: define WAVEGEN_SYNC_EN to add the sync restart input.
// -----------------------------------------------------------------------------
module wavegen
  import wavegen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic      clk,
  input  logic      reset,
  wavegen_if.slave  bus
);

  // 25% threshold out of reset.
  localparam logic [WIDTH-1:0] DUTY_RST = {2'b01, {(WIDTH - 2){1'b0}}};

  logic [WIDTH-1:0] r_acc;
  logic             r_wrap;
  logic [WIDTH-1:0] r_duty;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_wave;

  logic [WIDTH:0]   w_step_x;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_tri;
  dir_e             w_dir_unused;
  logic [WIDTH-1:0] w_saw;
  logic [WIDTH-1:0] w_revsaw;
  logic [WIDTH-1:0] w_pwm;
  logic [WIDTH-1:0] w_sel;

  assign w_step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
  assign w_sum    = {1'b0, r_acc} + w_step_x;
  assign w_carry  = w_sum[WIDTH];

  wavegen_tri #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_tri (
    .clk     (clk),
    .reset   (reset),
    .en      (bus.en),
`ifdef WAVEGEN_SYNC_EN
    .sync    (bus.sync),
`endif
    .step    (bus.step),
    .tri_val (w_tri),
    .dir     (w_dir_unused)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
      r_duty <= DUTY_RST;
      r_mode <= MODE_SAW;
      r_wave <= '0;
    end else begin
`ifdef WAVEGEN_SYNC_EN
      // Restart wins over en and never reports a wrap.
      if (bus.sync) begin
        r_acc  <= '0;
        r_wrap <= 1'b0;
        r_duty <= bus.duty;
        r_mode <= mode_e'(bus.mode);
      end else
`endif
      begin
        r_wrap <= bus.en & w_carry;
        if (bus.en) begin
          r_acc  <= w_sum[WIDTH-1:0];
          r_wave <= w_sel;
          if (w_carry) begin
            r_duty <= bus.duty;
            r_mode <= mode_e'(bus.mode);
          end
        end
      end
    end
  end

  assign w_saw    = r_acc;
  assign w_revsaw = ~r_acc;
  assign w_pwm    = {WIDTH{r_acc < r_duty}};

  always_comb begin
    w_sel = w_saw;
    case (r_mode)
      MODE_SAW:    w_sel = w_saw;
      MODE_REVSAW: w_sel = w_revsaw;
      MODE_TRI:    w_sel = w_tri;
      MODE_PWM:    w_sel = w_pwm;
      default:     w_sel = w_saw;
    endcase
  end

  assign bus.saw      = w_saw;
  assign bus.revsaw   = w_revsaw;
  assign bus.triangl  = w_tri;
  assign bus.meander  = {WIDTH{~r_acc[WIDTH-1]}};
  assign bus.pwm      = w_pwm;
  assign bus.wave_out = r_wave;
  assign bus.wrap     = r_wrap;

endmodule

// File: tb/tb_wavegen.sv
// -----------------------------------------------------------------------------
// tb_wavegen
// Directed bench for wavegen (WIDTH=8, STEP_W=8, 20 ns clock). Inputs change
// and outputs are sampled on the falling clock edge; edge numbers in the
// comments count rising edges since reset was released.
// -----------------------------------------------------------------------------
module tb_wavegen;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  wavegen_if #(.WIDTH(8), .STEP_W(8)) bus ();

  wavegen #(.WIDTH(8), .STEP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    bus.en   = 1'b0;
    bus.step = 8'd1;
    bus.duty = 8'd0;
    bus.mode = 2'd0;
`ifdef WAVEGEN_SYNC_EN
    bus.sync = 1'b0;
`endif
    #50;
    chk("rst_saw",     32'(bus.saw),      32'd0);
    chk("rst_revsaw",  32'(bus.revsaw),   32'd255);
    chk("rst_tri",     32'(bus.triangl),  32'd0);
    chk("rst_meander", 32'(bus.meander),  32'd255);
    chk("rst_pwm",     32'(bus.pwm),      32'd255);
    chk("rst_wave",    32'(bus.wave_out), 32'd0);
    chk("rst_wrap",    32'(bus.wrap),     32'd0);
    #50;
    reset  = 1'b0;
    bus.en = 1'b1;
    #1;

    // step=1 ramp
    tick(1);   // edge 1
    chk("e1_saw",    32'(bus.saw),      32'd1);
    chk("e1_revsaw", 32'(bus.revsaw),   32'd254);
    chk("e1_tri",    32'(bus.triangl),  32'd1);
    chk("e1_wave",   32'(bus.wave_out), 32'd0);
    chk("e1_wrap",   32'(bus.wrap),     32'd0);
    bus.duty = 8'd96;  // mid-period: must wait for the wrap
    tick(62);  // edge 63
    chk("e63_pwm",   32'(bus.pwm),      32'd255);
    tick(1);   // edge 64
    chk("e64_pwm",   32'(bus.pwm),      32'd0);
    chk("e64_mndr",  32'(bus.meander),  32'd255);
    tick(64);  // edge 128
    chk("e128_saw",  32'(bus.saw),      32'd128);
    chk("e128_mndr", 32'(bus.meander),  32'd0);
    tick(127); // edge 255
    chk("e255_saw",  32'(bus.saw),      32'd255);
    chk("e255_rev",  32'(bus.revsaw),   32'd0);
    chk("e255_tri",  32'(bus.triangl),  32'd255);
    chk("e255_wrap", 32'(bus.wrap),     32'd0);
    chk("e255_wave", 32'(bus.wave_out), 32'd254);
    tick(1);   // edge 256: wrap, duty 96 taken
    chk("e256_saw",  32'(bus.saw),      32'd0);
    chk("e256_wrap", 32'(bus.wrap),     32'd1);
    chk("e256_tri",  32'(bus.triangl),  32'd254);
    chk("e256_pwm",  32'(bus.pwm),      32'd255);
    chk("e256_wave", 32'(bus.wave_out), 32'd255);
    tick(1);   // edge 257
    chk("e257_wrap", 32'(bus.wrap),     32'd0);
    tick(94);  // edge 351
    chk("e351_pwm",  32'(bus.pwm),      32'd255);
    tick(1);   // edge 352
    chk("e352_pwm",  32'(bus.pwm),      32'd0);
    chk("e352_mndr", 32'(bus.meander),  32'd255);
    tick(158); // edge 510
    chk("e510_saw",  32'(bus.saw),      32'd254);
    chk("e510_tri",  32'(bus.triangl),  32'd0);

    // step=3 across the wrap, mode=2 taken there
    bus.step = 8'd3;
    bus.mode = 2'd2;
    tick(1);   // edge 511
    chk("e511_saw",  32'(bus.saw),      32'd1);
    chk("e511_wrap", 32'(bus.wrap),     32'd1);
    chk("e511_tri",  32'(bus.triangl),  32'd3);
    chk("e511_wave", 32'(bus.wave_out), 32'd254);
    chk("e511_pwm",  32'(bus.pwm),      32'd255);
    tick(1);   // edge 512
    chk("e512_saw",  32'(bus.saw),      32'd4);
    chk("e512_tri",  32'(bus.triangl),  32'd6);
    chk("e512_wave", 32'(bus.wave_out), 32'd3);
    chk("e512_wrap", 32'(bus.wrap),     32'd0);

    // freeze for 50 cycles
    bus.en = 1'b0;
    tick(50);
    chk("frz_saw",   32'(bus.saw),      32'd4);
    chk("frz_rev",   32'(bus.revsaw),   32'd251);
    chk("frz_tri",   32'(bus.triangl),  32'd6);
    chk("frz_wave",  32'(bus.wave_out), 32'd3);
    chk("frz_wrap",  32'(bus.wrap),     32'd0);
    bus.en = 1'b1;
    tick(1);
    chk("res_saw",   32'(bus.saw),      32'd7);
    chk("res_tri",   32'(bus.triangl),  32'd9);
    chk("res_wave",  32'(bus.wave_out), 32'd6);

    // asynchronous reset pulse mid-period
    #2;
    reset = 1'b1;
    #3;
    chk("arst_saw",  32'(bus.saw),      32'd0);
    chk("arst_rev",  32'(bus.revsaw),   32'd255);
    chk("arst_tri",  32'(bus.triangl),  32'd0);
    chk("arst_wave", 32'(bus.wave_out), 32'd0);
    chk("arst_pwm",  32'(bus.pwm),      32'd255);
    chk("arst_wrap", 32'(bus.wrap),     32'd0);
    #27;
    reset = 1'b0;
    @(negedge clk);

    // step=100 triangle sequence
    bus.step = 8'd100;
    tick(1);
    chk("s1_saw",    32'(bus.saw),      32'd100);
    chk("s1_tri",    32'(bus.triangl),  32'd100);
    tick(1);
    chk("s2_tri",    32'(bus.triangl),  32'd200);
    chk("s2_pwm",    32'(bus.pwm),      32'd0);
    chk("s2_wave",   32'(bus.wave_out), 32'd100);
    tick(1);
    chk("s3_saw",    32'(bus.saw),      32'd44);
    chk("s3_wrap",   32'(bus.wrap),     32'd1);
    chk("s3_tri",    32'(bus.triangl),  32'd255);
    chk("s3_pwm",    32'(bus.pwm),      32'd255);
    chk("s3_wave",   32'(bus.wave_out), 32'd200);
    tick(1);
    chk("s4_tri",    32'(bus.triangl),  32'd155);
    chk("s4_wave",   32'(bus.wave_out), 32'd255);
    chk("s4_wrap",   32'(bus.wrap),     32'd0);
    tick(1);
    chk("s5_tri",    32'(bus.triangl),  32'd55);
    chk("s5_wave",   32'(bus.wave_out), 32'd155);
    tick(1);
    chk("s6_tri",    32'(bus.triangl),  32'd0);
    tick(1);
    chk("s7_tri",    32'(bus.triangl),  32'd100);
    chk("s7_saw",    32'(bus.saw),      32'd188);

    // duty=0: pwm never high
    bus.duty = 8'd0;
    tick(1);
    chk("d0_saw",    32'(bus.saw),      32'd32);
    chk("d0_wrap",   32'(bus.wrap),     32'd1);
    chk("d0_pwm",    32'(bus.pwm),      32'd0);

    // duty=255: pwm low only at acc=255
    bus.duty = 8'd255;
    tick(3);
    chk("d255_saw",  32'(bus.saw),      32'd76);
    chk("d255_wrap", 32'(bus.wrap),     32'd1);
    chk("d255_pwm",  32'(bus.pwm),      32'd255);
    bus.step = 8'd179;
    tick(1);
    chk("dmax_saw",  32'(bus.saw),      32'd255);
    chk("dmax_pwm",  32'(bus.pwm),      32'd0);
    chk("dmax_tri",  32'(bus.triangl),  32'd0);

    // step=0 holds, no wrap
    bus.step = 8'd0;
    tick(1);
    chk("z_saw",     32'(bus.saw),      32'd255);
    chk("z_wrap",    32'(bus.wrap),     32'd0);

    // en low on the would-be wrap: no wrap, no capture
    bus.step = 8'd1;
    bus.en   = 1'b0;
    bus.mode = 2'd0;
    bus.duty = 8'd7;
    tick(1);
    chk("nw_saw",    32'(bus.saw),      32'd255);
    chk("nw_wrap",   32'(bus.wrap),     32'd0);
    bus.en   = 1'b1;
    bus.step = 8'd0;
    tick(1);
    chk("nc_wave",   32'(bus.wave_out), 32'd0);
    chk("nc_saw",    32'(bus.saw),      32'd255);
    bus.step = 8'd1;
    tick(1);
    chk("cw_saw",    32'(bus.saw),      32'd0);
    chk("cw_wrap",   32'(bus.wrap),     32'd1);
    chk("cw_pwm",    32'(bus.pwm),      32'd255);
    chk("cw_tri",    32'(bus.triangl),  32'd1);

`ifdef WAVEGEN_SYNC_EN
    bus.step = 8'd77;
    tick(1);
    chk("sy_pre",    32'(bus.saw),      32'd77);
    bus.sync = 1'b1;
    tick(1);
    bus.sync = 1'b0;
    chk("sy_saw",    32'(bus.saw),      32'd0);
    chk("sy_tri",    32'(bus.triangl),  32'd0);
    chk("sy_wrap",   32'(bus.wrap),     32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
